// File: rtl/sifo_pkg.sv
// Shared definitions for the stack interface: CU opcodes, default
// result-bus width and the per-cycle action codes used by hw_stack.
`timescale 1ns/1ps
package sifo_pkg;

  // Write-back opcodes the control unit turns into push/pop strobes
  localparam logic [4:0] OP_PUSH = 5'b00011;
  localparam logic [4:0] OP_POP  = 5'b00100;

  // Result-bus width shared with the CU and datapath
  localparam int DATA_W = 16;

  // What the stack does this cycle, resolved from the strobes and the
  // pre-edge full/empty status
  typedef enum logic [2:0] {
    ACT_HOLD,       // no strobe
    ACT_PUSH,       // push into free slot
    ACT_POP,        // pop a valid entry
    ACT_REPLACE,    // push&pop on non-empty: overwrite top in place
    ACT_PUSH_UNF,   // push&pop on empty: push done, pop dropped
    ACT_DROP_PUSH,  // push on full: dropped, overflow flagged
    ACT_DROP_POP    // pop on empty: dropped, underflow flagged
  } action_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: register array with one synchronous write port and one
// asynchronous read port so the top entry is visible in the pop cycle.
`timescale 1ns/1ps
module stack_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are deliberately not reset; sp alone defines validity
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write the selected entry on the clock edge
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hw_stack.sv
// Hardware LIFO stack answering the CU write-back push/pop strobes.
// Holds the stack pointer, sticky error flags and high-water mark; the
// top entry is presented combinationally so a pop can be consumed in the
// same cycle it is issued.
`timescale 1ns/1ps
module hw_stack
  import sifo_pkg::*;
#(
  parameter int DATA_W = sifo_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              unf,
  output logic [CNT_W-1:0]  hwm
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_hwm;
  logic              r_ovf;
  logic              r_unf;

  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_sp_m1;
  logic [CNT_W-1:0]  w_sp_next;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [DATA_W-1:0] w_top;
  action_e           w_act;

  // Status is decoded from sp only; sp saturates because of the drop rules
  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == CNT_W'(DEPTH));
  assign w_sp_m1 = r_sp - CNT_W'(1);

  // Classify this cycle's strobes against the pre-edge status
  always_comb begin
    w_act = ACT_HOLD;
    case ({push, pop})
      2'b10:   w_act = w_full  ? ACT_DROP_PUSH : ACT_PUSH;
      2'b01:   w_act = w_empty ? ACT_DROP_POP  : ACT_POP;
      2'b11:   w_act = w_empty ? ACT_PUSH_UNF  : ACT_REPLACE;
      default: w_act = ACT_HOLD;
    endcase
  end

  // Turn the action into write-port controls, next sp and error sets
  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_sp[ADDR_W-1:0];
    w_sp_next = r_sp;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_act)
      ACT_PUSH: begin
        w_we      = 1'b1;
        w_sp_next = r_sp + CNT_W'(1);
      end
      ACT_POP: begin
        w_sp_next = w_sp_m1;
      end
      ACT_REPLACE: begin
        // Top is overwritten in place; legal even when full
        w_we    = 1'b1;
        w_waddr = w_sp_m1[ADDR_W-1:0];
      end
      ACT_PUSH_UNF: begin
        w_we      = 1'b1;
        w_waddr   = '0;
        w_sp_next = CNT_W'(1);
        w_unf_set = 1'b1;
      end
      ACT_DROP_PUSH: w_ovf_set = 1'b1;
      ACT_DROP_POP:  w_unf_set = 1'b1;
      default: ;
    endcase
  end

  // Pointer, sticky errors and high-water mark; a new error beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_hwm <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_sp  <= w_sp_next;
      r_hwm <= (w_sp_next > r_hwm) ? w_sp_next : r_hwm;
      r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
      r_unf <= w_unf_set | (r_unf & ~err_clr);
    end
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (wdata),
    .i_raddr (w_sp_m1[ADDR_W-1:0]),
    .o_rdata (w_top)
  );

  assign rdata = w_empty ? '0 : w_top;
  assign empty = w_empty;
  assign full  = w_full;
  assign count = r_sp;
  assign ovf   = r_ovf;
  assign unf   = r_unf;
  assign hwm   = r_hwm;

endmodule

// File: tb/tb_hw_stack.sv
// Scoreboard bench for hw_stack: the stimulus process drives one cycle at
// each falling edge and queues the values it expects in that cycle; the
// monitor samples 2ns later and pops every expectation tagged for it.
`timescale 1ns/1ps
module tb_hw_stack;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum int {K_COUNT, K_EMPTY, K_FULL, K_OVF, K_UNF, K_HWM, K_RDATA} kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] wdata;
  logic              err_clr;
  logic [DATA_W-1:0] rdata;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              unf;
  logic [CNT_W-1:0]  hwm;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 0;

  hw_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wdata),
    .err_clr (err_clr),
    .rdata   (rdata),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovf     (ovf),
    .unf     (unf),
    .hwm     (hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(kind_e k);
    case (k)
      K_COUNT: return 16'(count);
      K_EMPTY: return 16'(empty);
      K_FULL:  return 16'(full);
      K_OVF:   return 16'(ovf);
      K_UNF:   return 16'(unf);
      K_HWM:   return 16'(hwm);
      default: return rdata;
    endcase
  endfunction

  // Drive one cycle's inputs at the falling edge
  task automatic step(input logic p, input logic o, input logic [15:0] d, input logic c);
    @(negedge clk);
    push = p; pop = o; wdata = d; err_clr = c;
  endtask

  task automatic expect1(input kind_e k, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.kind = k; e.exp = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic expect_all(input string tag, input int c, input int e, input int f,
                            input int o, input int u, input int h, input logic [15:0] r);
    expect1(K_COUNT, 16'(c), {tag, ".count"});
    expect1(K_EMPTY, 16'(e), {tag, ".empty"});
    expect1(K_FULL,  16'(f), {tag, ".full"});
    expect1(K_OVF,   16'(o), {tag, ".ovf"});
    expect1(K_UNF,   16'(u), {tag, ".unf"});
    expect1(K_HWM,   16'(h), {tag, ".hwm"});
    expect1(K_RDATA, r,      {tag, ".rdata"});
  endtask

  // Monitor: compare everything tagged for the current cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        logic [15:0] a;
        e = q.pop_front();
        a = actual(e.kind);
        n_checks++;
        if (e.cyc < cyc) begin
          n_errors++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else if (a !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, a, e.exp);
        end else begin
          $display("ok   %s = 0x%04h (cycle %0d)", e.name, a, cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0; err_clr = 1'b0;

    // Reset state
    step(0, 0, 16'h0, 0);
    expect_all("reset", 0, 1, 0, 0, 0, 0, 16'h0000);
    rst_n = 1'b1;

    // 1: three pushes
    step(1, 0, 16'h0011, 0);
    step(1, 0, 16'h0022, 0);
    step(1, 0, 16'h0033, 0);
    step(0, 0, 16'h0, 0);
    expect_all("t1", 3, 0, 0, 0, 0, 3, 16'h0033);

    // 2: three pops, top sampled in the pop cycle
    step(0, 1, 16'h0, 0);
    expect1(K_RDATA, 16'h0033, "t2.pop0");
    step(0, 1, 16'h0, 0);
    expect1(K_RDATA, 16'h0022, "t2.pop1");
    step(0, 1, 16'h0, 0);
    expect1(K_RDATA, 16'h0011, "t2.pop2");
    step(0, 0, 16'h0, 0);
    expect_all("t2.end", 0, 1, 0, 0, 0, 3, 16'h0000);

    // 3: underflow, clear, then error coinciding with clear
    step(0, 1, 16'h0, 0);
    step(0, 0, 16'h0, 1);
    expect1(K_UNF, 16'h1, "t3.unf_set");
    expect1(K_COUNT, 16'h0, "t3.count");
    step(0, 0, 16'h0, 0);
    expect1(K_UNF, 16'h0, "t3.unf_clr");
    step(0, 1, 16'h0, 0);
    step(0, 1, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    expect1(K_UNF, 16'h1, "t3.err_beats_clr");
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    expect1(K_UNF, 16'h0, "t3.unf_clr2");

    // 4: fill, overflow, replace on full
    for (int i = 0; i < DEPTH; i++) step(1, 0, 16'h0100 + 16'(i), 0);
    step(0, 0, 16'h0, 0);
    expect_all("t4.filled", 16, 0, 1, 0, 0, 16, 16'h010F);
    step(1, 0, 16'hBEEF, 0);
    step(0, 0, 16'h0, 0);
    expect_all("t4.ovf", 16, 0, 1, 1, 0, 16, 16'h010F);
    step(0, 0, 16'h0, 1);
    step(1, 1, 16'hCAFE, 0);
    expect1(K_RDATA, 16'h010F, "t4.replace_old_top");
    expect1(K_OVF, 16'h0, "t4.ovf_cleared");
    step(0, 0, 16'h0, 0);
    expect_all("t4.replaced", 16, 0, 1, 0, 0, 16, 16'hCAFE);

    // 5: drain, then push&pop on empty
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 16'h0, 0);
      expect1(K_RDATA, (i == 0) ? 16'hCAFE : 16'h010F - 16'(i), "t5.drain");
    end
    step(0, 0, 16'h0, 0);
    expect1(K_EMPTY, 16'h1, "t5.empty");
    step(1, 1, 16'h1234, 0);
    expect1(K_RDATA, 16'h0000, "t5.pp_rdata_empty");
    step(0, 0, 16'h0, 0);
    expect_all("t5.pp", 1, 0, 0, 0, 1, 16, 16'h1234);

    // 6: five pushes, then asynchronous reset between edges
    step(0, 1, 16'h0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 16'h00A0 + 16'(i), 0);
    step(0, 0, 16'h0, 0);
    expect_all("t6.pre", 5, 0, 0, 0, 1, 16, 16'h00A4);
    step(1, 0, 16'h0055, 0);
    rst_n = 1'b0;
    expect_all("t6.async_rst", 0, 1, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 16'h0, 0);
    expect1(K_COUNT, 16'h0, "t6.push_lost");
    rst_n = 1'b1;
    step(0, 0, 16'h0, 0);
    expect_all("t6.after", 0, 1, 0, 0, 0, 0, 16'h0000);

    repeat (3) @(negedge clk);
    #5;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL %s: never compared, expected 0x%04h", e.name, e.exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
